// File: rtl/io_pkg.sv
// Shared types and constants for the ecall "read input" path.
// Holds the controller state enum, data width and service code.
package io_pkg;

    localparam int IO_DATA_W = 32;

    // ecall service code the Controller decodes as "read input"
    localparam logic [31:0] ECALL_READ_INPUT = 32'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_RELEASE,
        S_ARMED,
        S_CAPTURE,
        S_RESP,
        S_POST_RELEASE
    } io_state_t;

endpackage

// File: rtl/io_input_ctrl_if.sv
// CPU-side request/response bundle of the input controller.
// master: CPU (drives req, sign_ext); slave: io_input_ctrl.
interface io_input_ctrl_if;
    import io_pkg::*;

    logic                 req;
    logic                 sign_ext;
    logic                 stall;
    logic                 ack;
    logic                 busy;
    logic [IO_DATA_W-1:0] data_out;

    modport master (
        output req, sign_ext,
        input  stall, ack, busy, data_out
    );

    modport slave (
        input  req, sign_ext,
        output stall, ack, busy, data_out
    );

endinterface

// File: rtl/io_debouncer.sv
// 2-FF synchronizer plus debounce counter for one raw button.
// Ports: clock, reset (async, active-low), raw (async in), db (level).
module io_debouncer #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // db only flips after DEBOUNCE_CYCLES consecutive mismatching
    // samples; any matching sample restarts the run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
                db  <= ~db;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_ctrl.sv
// Services the ecall read-input request: waits for a fresh button
// press, captures the synced switches and returns them extended.
// Ports: clock, reset (async, active-low), sw_in, button_in,
// io (slave: req, sign_ext in; stall, ack, busy, data_out out).
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int SW_WIDTH        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                button_in,
    io_input_ctrl_if.slave      io
);

    localparam int PAD = IO_DATA_W - SW_WIDTH;

    logic [SW_WIDTH-1:0]  sw_m;
    logic [SW_WIDTH-1:0]  sw_s;
    logic                 db;
    io_state_t            state;
    logic                 ack_q;
    logic [IO_DATA_W-1:0] data_q;

    io_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .clock (clock),
        .reset (reset),
        .raw   (button_in),
        .db    (db)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw_in;
            sw_s <= sw_m;
        end
    end

    // A button already down at request time must be released first,
    // so a single press is never consumed by two requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (io.req)
                        state <= db ? S_PRE_RELEASE : S_ARMED;
                end
                S_PRE_RELEASE: begin
                    if (!io.req)
                        state <= S_IDLE;
                    else if (!db)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!io.req)
                        state <= S_IDLE;
                    else if (db)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    data_q <= {{PAD{io.sign_ext & sw_s[SW_WIDTH-1]}},
                               sw_s};
                    ack_q  <= 1'b1;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    state <= S_POST_RELEASE;
                end
                S_POST_RELEASE: begin
                    if (!db)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.stall    = io.req & ~ack_q;
    assign io.ack      = ack_q;
    assign io.data_out = data_q;
    assign io.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Randomized + directed bench for io_input_ctrl against a
// cycle-level reference model of the read-input behaviour.
module tb_io_input_ctrl;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [7:0] sw_in;
    logic       button_in;

    io_input_ctrl_if bus ();

    io_input_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SW_WIDTH        (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_in     (sw_in),
        .button_in (button_in),
        .io        (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt = 0;
    bit auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model
    typedef enum int {M_IDLE, M_PRE, M_ARM, M_CAP, M_RESP, M_POST} mst_t;
    mst_t        m_st;
    bit          m_db;
    int          m_run;
    bit          m_ack;
    logic [31:0] m_data;
    bit          bh [2];
    logic [7:0]  swh [2];

    task automatic model_reset();
        m_st   = M_IDLE;
        m_db   = 1'b0;
        m_run  = 0;
        m_ack  = 1'b0;
        m_data = 32'h0;
        bh[0]  = 1'b0;
        bh[1]  = 1'b0;
        swh[0] = 8'h0;
        swh[1] = 8'h0;
    endtask

    // one clock edge: inputs seen are those sampled by the DUT
    task automatic model_step();
        bit         syn;
        logic [7:0] sws;
        if (!reset) return;
        syn   = bh[1];
        sws   = swh[1];
        m_ack = 1'b0;
        case (m_st)
            M_IDLE: if (bus.req) m_st = m_db ? M_PRE : M_ARM;
            M_PRE:  if (!bus.req) m_st = M_IDLE;
                    else if (!m_db) m_st = M_ARM;
            M_ARM:  if (!bus.req) m_st = M_IDLE;
                    else if (m_db) m_st = M_CAP;
            M_CAP: begin
                m_data = bus.sign_ext ? 32'($signed(sws)) : 32'(sws);
                m_ack  = 1'b1;
                m_st   = M_RESP;
            end
            M_RESP: m_st = M_POST;
            M_POST: if (!m_db) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
        if (syn != m_db) begin
            m_run++;
            if (m_run == D) begin
                m_db  = !m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        bh[1]  = bh[0];
        bh[0]  = button_in;
        swh[1] = swh[0];
        swh[0] = sw_in;
    endtask

    task automatic compare();
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("data", bus.data_out, m_data);
        chk("busy", 32'(bus.busy), 32'(m_st != M_IDLE));
        chk("stall", 32'(bus.stall), 32'(bus.req & ~m_ack));
        if (bus.ack) begin
            ack_cnt++;
            if (auto_drop) bus.req = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        cyc();
        reset = 1'b1;
    endtask

    // full read: request, press for 'hold' cycles, release, settle
    task automatic read_once(input logic [7:0] sw, input bit sx,
                             input int hold, output int lat);
        lat       = -1;
        ack_cnt   = 0;
        sw_in     = sw;
        bus.sign_ext = sx;
        bus.req   = 1'b1;
        #1;
        chk("stall_rise", 32'(bus.stall), 32'd1);
        cyc();
        button_in = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            cyc();
            if (bus.ack && lat < 0) lat = i;
        end
        button_in = 1'b0;
        wait_idle();
        chk("read_acks", 32'(ack_cnt), 32'd1);
    endtask

    int          lat;
    logic [31:0] prev;

    initial begin
        reset        = 1'b0;
        sw_in        = 8'h0;
        button_in    = 1'b0;
        bus.req      = 1'b0;
        bus.sign_ext = 1'b0;
        model_reset();
        #2;
        chk("init_ack", 32'(bus.ack), 32'd0);
        chk("init_data", bus.data_out, 32'h0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        bus.req = 1'b1;
        #1;
        chk("init_stall", 32'(bus.stall), 32'd1);
        bus.req = 1'b0;
        run(2);
        reset = 1'b1;
        run(2);

        // basic read
        read_once(8'h5A, 1'b0, 10, lat);
        chk("basic_lat", 32'(lat), 32'd8);
        chk("basic_data", bus.data_out, 32'h0000005A);

        // sign extension
        read_once(8'hF3, 1'b1, 10, lat);
        chk("sext_data", bus.data_out, 32'hFFFFFFF3);
        read_once(8'hF3, 1'b0, 10, lat);
        chk("zext_data", bus.data_out, 32'h000000F3);

        // bounce rejection
        ack_cnt = 0;
        sw_in   = 8'h3C;
        bus.req = 1'b1;
        cyc();
        for (int p = 0; p < 5; p++) begin
            button_in = 1'b1;
            run(3);
            button_in = 1'b0;
            run(1);
        end
        chk("bounce_acks", 32'(ack_cnt), 32'd0);
        chk("bounce_busy", 32'(bus.busy), 32'd1);
        chk("bounce_data", bus.data_out, 32'h000000F3);
        button_in = 1'b1;
        run(6);
        button_in = 1'b0;
        wait_idle();
        chk("bounce_press_acks", 32'(ack_cnt), 32'd1);
        chk("bounce_press_data", bus.data_out, 32'h0000003C);

        // held button at request time
        ack_cnt   = 0;
        prev      = bus.data_out;
        button_in = 1'b1;
        run(10);
        sw_in   = 8'h11;
        bus.req = 1'b1;
        run(10);
        chk("held_acks", 32'(ack_cnt), 32'd0);
        chk("held_busy", 32'(bus.busy), 32'd1);
        chk("held_data", bus.data_out, prev);
        button_in = 1'b0;
        run(8);
        chk("held_rel_acks", 32'(ack_cnt), 32'd0);
        button_in = 1'b1;
        run(10);
        button_in = 1'b0;
        wait_idle();
        chk("held_new_acks", 32'(ack_cnt), 32'd1);
        chk("held_new_data", bus.data_out, 32'h00000011);

        // abort while armed
        ack_cnt = 0;
        prev    = bus.data_out;
        sw_in   = 8'h77;
        bus.req = 1'b1;
        run(3);
        chk("abort_armed", 32'(bus.busy), 32'd1);
        bus.req = 1'b0;
        cyc();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_acks", 32'(ack_cnt), 32'd0);
        chk("abort_data", bus.data_out, prev);

        // async reset in CAPTURE
        ack_cnt      = 0;
        sw_in        = 8'h81;
        bus.sign_ext = 1'b1;
        bus.req      = 1'b1;
        cyc();
        button_in = 1'b1;
        run(7);
        chk("cap_busy", 32'(bus.busy), 32'd1);
        chk("cap_no_ack", 32'(ack_cnt), 32'd0);
        pulse_reset();
        button_in = 1'b0;
        bus.req   = 1'b0;
        run(2);
        chk("rst_acks", 32'(ack_cnt), 32'd0);
        read_once(8'h81, 1'b1, 10, lat);
        chk("after_rst_data", bus.data_out, 32'hFFFFFF81);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (!bus.req && ($urandom % 4) == 0) begin
                bus.req      = 1'b1;
                bus.sign_ext = 1'($urandom);
            end else if (bus.req && ($urandom % 64) == 0) begin
                bus.req = 1'b0;
            end
            if (($urandom % 3) == 0) sw_in = 8'($urandom);
            if (($urandom % 6) == 0) button_in = ~button_in;
            if (($urandom % 700) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
